spectrogram_buffer: RTL and testbench
=====================================

Name: spectrogram_buffer

Overview:
- Sits directly downstream of the FFT magnitude path. Consumes its real-valued stream: 16-bit magnitudes, 257 bins per frame, tlast on bin 256.
- Captures REQUIRED_FRAMES consecutive frames into a block RAM as a contiguous frame-major spectrogram.
- Exposes the stored spectrogram through a random-access read port to the classifier, with start/full/release handshaking.
- Never back-pressures upstream; in_ready is held high so the FFT never stalls.

Parameters:
- DW, 16, magnitude sample width.
- NBINS, 257, bins per frame.
- NFRAMES, 97, frames per spectrogram.
- AW, $clog2(NBINS*NFRAMES) (=15), flat address width.

Ports:
- clk  in  1  clock
- arstn  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse, begin capture (driven from the capture trigger)
- in_tdata  in  DW  magnitude sample
- in_tlast  in  1  last bin of frame
- in_valid  in  1  sample valid
- in_ready  out  1  always 1 after reset
- rd_en  in  1  read request
- rd_addr  in  AW  flat address = frame*NBINS + bin
- rd_data  out  DW  read data
- rd_valid  out  1  rd_data valid
- release_i  in  1  consumer finished, buffer may be reused
- full  out  1  spectrogram complete and stable
- busy  out  1  state is FILL or RESYNC
- frame_count  out  7  frames completed in current capture
- err_len  out  1  sticky: frame length mismatch seen
- err_ovf  out  1  sticky: beats dropped while FULL

Behaviour:
- Reset: asynchronous, active-low, from arstn. All outputs 0 except in_ready, which is 1 one cycle after reset release. State goes to IDLE; wptr, frame_base and frame_count clear to 0. RAM contents are not cleared.
- Handshake: a beat is accepted when in_valid && in_ready. in_ready=1 in every state; acceptance never stalls.
- States: IDLE, FILL, RESYNC, FULL.
  - IDLE: accepted beats are discarded. start -> FILL with wptr=0, frame_base=0, frame_count=0, err_len and err_ovf cleared.
  - FILL: each accepted beat writes RAM[wptr] and increments wptr. Bin index = wptr - frame_base. The frame closes on the first of: in_tlast, or bin==NBINS-1.
    - Normal close (tlast at bin NBINS-1): no error.
    - tlast before bin NBINS-1: err_len<=1. The unwritten remainder of the slot keeps stale data.
    - bin NBINS-1 reached without tlast: err_len<=1 and go to RESYNC.
    - On any close: frame_base<=frame_base+NBINS, wptr<=frame_base+NBINS, frame_count+=1.
    - If the closing frame makes frame_count==NFRAMES: go to FULL and assert full the next cycle. This takes precedence over RESYNC.
  - RESYNC: accepted beats are discarded without writing. An accepted tlast returns the block to FILL. The frame was already counted.
  - FULL: full=1 and RAM writes are inhibited. Any accepted beat sets err_ovf.
    - release_i -> IDLE.
    - start in FULL is ignored. start and release_i in the same cycle: release wins, start is ignored.
- start while FILL or RESYNC is ignored; no restart mid-capture.
- Write address is formed incrementally with no multiplier. The address never exceeds NBINS*NFRAMES-1.
- Read port:
  - rd_en with rd_addr gives rd_data/rd_valid exactly 1 cycle later, in any state.
  - Contents are only guaranteed coherent while full=1.
  - rd_addr >= NBINS*NFRAMES returns 0 with rd_valid=1.
  - Simultaneous read and write to the same address returns the old data (read-first).
- frame_count saturates at NFRAMES.
- Reset mid-capture: IDLE immediately; the next capture requires a new start.

Test Plan:
- Reset, then start; stream 97 frames of 257 beats with tlast on bin 256 and in_tdata=frame*1000+bin mod 2^16 -> full=1 one cycle after the last beat, frame_count=97, err_len=0. rd_addr=5*257+10 returns 5010 one cycle after rd_en.
- Frame 3 sends tlast on bin 200 -> err_len=1; frame 4 data sits at base 4*257; total still 97 frames; full asserts.
- Frame 2 sends 300 beats with tlast on beat 299 -> err_len=1; beats 257..299 are not written (RAM[3*257] holds frame 3, bin 0); capture completes normally.
- In FULL, drive 10 more beats -> err_ovf=1, RAM unchanged, in_ready stays 1. Pulse start and release_i together -> IDLE, full=0, no new capture. Then start -> FILL, errors cleared.
- Assert arstn low at frame 40 -> IDLE, frame_count=0, full=0, busy=0. After release, beats without start are discarded.
- Random in_valid gaps, with back-to-back reads issued while FILL -> rd_valid follows rd_en with 1-cycle latency. rd_addr=24929 returns 0.

Source files
------------

// File: rtl/spectrogram_buffer.sv
// -----------------------------------------------------------------------------
// spectrogram_buffer
//
// Captures NFRAMES consecutive frames of FFT magnitudes (NBINS bins each, tlast
// on the final bin) into a block RAM. The RAM holds them as a frame-major
// spectrogram, and the classifier reads it back through a random-access port.
// The upstream stream is never back-pressured: in_ready is held high once the
// block is out of reset.
//
// Ports:
//   clk          clock
//   arstn        asynchronous active-low reset
//   start        single-cycle pulse, begins a capture (honoured only in IDLE)
//   in_tdata     magnitude sample
//   in_tlast     marks the last bin of a frame
//   in_valid     sample valid
//   in_ready     always 1 after reset
//   rd_en        read request
//   rd_addr      flat read address = frame*NBINS + bin
//   rd_data      read data, one cycle after rd_en (0 for out-of-range addresses)
//   rd_valid     rd_data valid
//   release_i    consumer done, buffer may be reused
//   full         spectrogram complete and stable
//   busy         capture in progress (FILL or RESYNC)
//   frame_count  frames closed in the current capture
//   err_len      sticky: a frame arrived with the wrong length
//   err_ovf      sticky: beats arrived while the buffer was full
// -----------------------------------------------------------------------------
module spectrogram_buffer #(
  parameter int DW      = 16,
  parameter int NBINS   = 257,
  parameter int NFRAMES = 97,
  parameter int AW      = $clog2(NBINS * NFRAMES)
) (
  input  logic          clk,
  input  logic          arstn,
  input  logic          start,
  input  logic [DW-1:0] in_tdata,
  input  logic          in_tlast,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  input  logic          release_i,
  output logic          full,
  output logic          busy,
  output logic [6:0]    frame_count,
  output logic          err_len,
  output logic          err_ovf
);

  localparam int            DEPTH      = NBINS * NFRAMES;
  localparam logic [AW-1:0] NBINS_A    = AW'(NBINS);
  localparam logic [AW-1:0] LAST_BIN   = AW'(NBINS - 1);
  localparam logic [AW-1:0] ONE_A      = AW'(1);
  localparam logic [AW:0]   DEPTH_W    = (AW + 1)'(DEPTH);
  localparam logic [6:0]    LAST_FRAME = 7'(NFRAMES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FILL   = 2'd1,
    S_RESYNC = 2'd2,
    S_FULL   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] base_q, base_d;
  logic [6:0]    count_q, count_d;
  logic          err_len_q, err_len_d;
  logic          err_ovf_q, err_ovf_d;
  logic          in_ready_q;
  logic          rd_valid_q;
  logic          rd_oob_q;
  logic [DW-1:0] mem_rd_q;

  logic          accept;
  logic          wr_en;
  logic [AW-1:0] bin;
  logic          last_bin;
  logic          rd_oob;

  logic [DW-1:0] mem [DEPTH];

  assign accept   = in_valid && in_ready_q;
  // The bin index is derived from the running write pointer, so the write
  // address never needs a frame*NBINS multiply.
  assign bin      = wptr_q - base_q;
  assign last_bin = (bin == LAST_BIN);
  assign rd_oob   = ({1'b0, rd_addr} >= DEPTH_W);

  // ---------------------------------------------------------------------------
  // Control state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q    <= S_IDLE;
      wptr_q     <= '0;
      base_q     <= '0;
      count_q    <= '0;
      err_len_q  <= 1'b0;
      err_ovf_q  <= 1'b0;
      in_ready_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_oob_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      base_q     <= base_d;
      count_q    <= count_d;
      err_len_q  <= err_len_d;
      err_ovf_q  <= err_ovf_d;
      in_ready_q <= 1'b1;
      rd_valid_q <= rd_en;
      rd_oob_q   <= rd_en && rd_oob;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    wptr_d    = wptr_q;
    base_d    = base_q;
    count_d   = count_q;
    err_len_d = err_len_q;
    err_ovf_d = err_ovf_q;
    wr_en     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_FILL;
          wptr_d    = '0;
          base_d    = '0;
          count_d   = '0;
          err_len_d = 1'b0;
          err_ovf_d = 1'b0;
        end
      end

      S_FILL: begin
        if (accept) begin
          wr_en = 1'b1;
          if (in_tlast || last_bin) begin
            // Close the frame. A short frame leaves the rest of its slot stale.
            // A long frame is cut at the slot end and the tail is dropped.
            base_d  = base_q + NBINS_A;
            wptr_d  = base_q + NBINS_A;
            count_d = count_q + 7'd1;
            if (!(in_tlast && last_bin)) begin
              err_len_d = 1'b1;
            end
            // Completing the spectrogram beats resyncing on an overlong frame.
            if (count_q == LAST_FRAME) begin
              state_d = S_FULL;
            end else if (!in_tlast) begin
              state_d = S_RESYNC;
            end
          end else begin
            wptr_d = wptr_q + ONE_A;
          end
        end
      end

      S_RESYNC: begin
        if (accept && in_tlast) begin
          state_d = S_FILL;
        end
      end

      S_FULL: begin
        if (accept) begin
          err_ovf_d = 1'b1;
        end
        // A start pulse in the same cycle is ignored: release wins.
        if (release_i) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Spectrogram RAM. The read is registered and read-first, and there is no
  // reset on this path so it maps onto block RAM.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wptr_q] <= in_tdata;
    end
    if (rd_en && !rd_oob) begin
      mem_rd_q <= mem[rd_addr];
    end
  end

  assign rd_data     = (rd_valid_q && !rd_oob_q) ? mem_rd_q : '0;
  assign rd_valid    = rd_valid_q;
  assign in_ready    = in_ready_q;
  assign full        = (state_q == S_FULL);
  assign busy        = (state_q == S_FILL) || (state_q == S_RESYNC);
  assign frame_count = count_q;
  assign err_len     = err_len_q;
  assign err_ovf     = err_ovf_q;

endmodule

// File: tb/tb_spectrogram_buffer.sv
// -----------------------------------------------------------------------------
// Testbench for spectrogram_buffer. A frame/bin-level reference model follows
// every clock edge, and a negedge process compares all outputs against it.
// Literal expectations at key points pin the model itself.
// -----------------------------------------------------------------------------
module tb_spectrogram_buffer;

  localparam int DW      = 16;
  localparam int NBINS   = 257;
  localparam int NFRAMES = 97;
  localparam int AW      = 15;
  localparam int DEPTH   = NBINS * NFRAMES;

  logic          clk       = 1'b0;
  logic          arstn     = 1'b0;
  logic          start     = 1'b0;
  logic [DW-1:0] in_tdata  = '0;
  logic          in_tlast  = 1'b0;
  logic          in_valid  = 1'b0;
  logic          rd_en     = 1'b0;
  logic [AW-1:0] rd_addr   = '0;
  logic          release_i = 1'b0;
  logic          in_ready;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          full;
  logic          busy;
  logic [6:0]    frame_count;
  logic          err_len;
  logic          err_ovf;

  always #5 clk = ~clk;

  spectrogram_buffer #(
    .DW(DW), .NBINS(NBINS), .NFRAMES(NFRAMES), .AW(AW)
  ) dut (
    .clk(clk), .arstn(arstn), .start(start),
    .in_tdata(in_tdata), .in_tlast(in_tlast), .in_valid(in_valid), .in_ready(in_ready),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .release_i(release_i), .full(full), .busy(busy), .frame_count(frame_count),
    .err_len(err_len), .err_ovf(err_ovf)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model, in terms of frames and bins of the capture
  // ---------------------------------------------------------------------------
  typedef enum {M_IDLE, M_FILL, M_DROP, M_DONE} mmode_t;
  mmode_t      m_mode;
  int          m_frame, m_bin;
  bit          m_err_len, m_err_ovf, m_ready;
  bit          m_rd_valid, m_rd_known;
  logic [15:0] m_rd_data;
  logic [15:0] m_ram   [DEPTH];
  bit          m_known [DEPTH];
  bit          chk_en  = 1'b0;
  bit          rand_rd = 1'b0;
  int          gap_pct = 0;

  task automatic model_reset();
    m_mode     = M_IDLE;
    m_frame    = 0;
    m_bin      = 0;
    m_err_len  = 1'b0;
    m_err_ovf  = 1'b0;
    m_ready    = 1'b0;
    m_rd_valid = 1'b0;
  endtask

  // Applies the inputs that were present at the clock edge just taken.
  task automatic model_step();
    bit acc;
    int a;
    if (!arstn) begin
      model_reset();
      return;
    end
    acc = in_valid && m_ready;
    // Read observes RAM contents before this edge's write.
    m_rd_valid = rd_en;
    if (rd_en) begin
      a = int'(rd_addr);
      if (a >= DEPTH) begin
        m_rd_known = 1'b1;
        m_rd_data  = 16'd0;
      end else begin
        m_rd_known = m_known[a];
        m_rd_data  = m_ram[a];
      end
    end
    case (m_mode)
      M_IDLE: if (start) begin
        m_mode    = M_FILL;
        m_frame   = 0;
        m_bin     = 0;
        m_err_len = 1'b0;
        m_err_ovf = 1'b0;
      end
      M_FILL: if (acc) begin
        a = m_frame * NBINS + m_bin;
        m_ram[a]   = in_tdata;
        m_known[a] = 1'b1;
        if (in_tlast || m_bin == NBINS - 1) begin
          if (!(in_tlast && m_bin == NBINS - 1)) m_err_len = 1'b1;
          m_frame++;
          m_bin = 0;
          if (m_frame == NFRAMES) m_mode = M_DONE;
          else if (!in_tlast) m_mode = M_DROP;
        end else begin
          m_bin++;
        end
      end
      M_DROP: if (acc && in_tlast) m_mode = M_FILL;
      M_DONE: begin
        if (acc) m_err_ovf = 1'b1;
        if (release_i) m_mode = M_IDLE;
      end
      default: m_mode = M_IDLE;
    endcase
    m_ready = 1'b1;
  endtask

  // Per-cycle comparison, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", int'(in_ready), int'(m_ready));
      chk("full", int'(full), int'(m_mode == M_DONE));
      chk("busy", int'(busy), int'(m_mode == M_FILL || m_mode == M_DROP));
      chk("frame_count", int'(frame_count), m_frame);
      chk("err_len", int'(err_len), int'(m_err_len));
      chk("err_ovf", int'(err_ovf), int'(m_err_ovf));
      chk("rd_valid", int'(rd_valid), int'(m_rd_valid));
      if (m_rd_valid && m_rd_known) chk("rd_data", int'(rd_data), int'(m_rd_data));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    start     = 1'b0;
    release_i = 1'b0;
    if (rand_rd) begin
      rd_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) rd_addr = AW'(DEPTH + $urandom_range(0, 100));
      else rd_addr = AW'($urandom_range(0, DEPTH - 1));
    end else begin
      rd_en = 1'b0;
    end
  endtask

  task automatic send_beat(input logic [15:0] d, input bit last);
    while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
      in_valid = 1'b0;
      tick();
    end
    in_valid = 1'b1;
    in_tdata = d;
    in_tlast = last;
    tick();
    in_valid = 1'b0;
    in_tlast = 1'b0;
  endtask

  task automatic send_frame(input int f, input int nbeats, input int tlast_at,
                            input logic [15:0] salt);
    for (int b = 0; b < nbeats; b++) begin
      send_beat(16'(f * 1000 + b) ^ salt, b == tlast_at);
    end
  endtask

  task automatic check_read(input int addr, input int exp, input string name);
    rd_en   = 1'b1;
    rd_addr = AW'(addr);
    tick();
    chk({name, "_valid"}, int'(rd_valid), 1);
    chk(name, int'(rd_data), exp);
  endtask

  // Time limit so the run can never hang
  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    chk_en = 1'b1;
    repeat (2) tick();
    chk("reset_full", int'(full), 0);
    chk("reset_in_ready", int'(in_ready), 0);
    arstn = 1'b1;
    tick();
    chk("in_ready_after_reset", int'(in_ready), 1);
    rand_rd = 1'b1;

    // Capture 1: clean frames, data = frame*1000+bin
    start = 1'b1;
    tick();
    for (int f = 0; f < NFRAMES; f++) send_frame(f, NBINS, NBINS - 1, 16'h0000);
    chk("c1_full", int'(full), 1);
    chk("c1_frame_count", int'(frame_count), 97);
    chk("c1_err_len", int'(err_len), 0);
    check_read(5 * 257 + 10, 5010, "c1_rd_5_10");
    check_read(24929, 0, "c1_rd_oob");
    check_read(96 * 257 + 256, 30720, "c1_rd_96_256");

    // Overflow while full, then start+release together
    for (int i = 0; i < 10; i++) send_beat(16'hBEEF, 1'b0);
    chk("ovf_err_ovf", int'(err_ovf), 1);
    chk("ovf_in_ready", int'(in_ready), 1);
    check_read(0, 0, "ovf_rd_0");
    start     = 1'b1;
    release_i = 1'b1;
    tick();
    chk("rel_full", int'(full), 0);
    chk("rel_busy", int'(busy), 0);
    for (int i = 0; i < 5; i++) send_beat(16'h1234, 1'b0);
    chk("idle_busy", int'(busy), 0);
    start = 1'b1;
    tick();
    chk("c2_busy", int'(busy), 1);
    chk("c2_err_ovf_cleared", int'(err_ovf), 0);
    chk("c2_frame_count0", int'(frame_count), 0);

    // Capture 2: gaps, long frame 2, short frame 3, salted data
    gap_pct = 12;
    for (int f = 0; f < NFRAMES; f++) begin
      if (f == 2) send_frame(f, 300, 299, 16'h8000);
      else if (f == 3) send_frame(f, 201, 200, 16'h8000);
      else send_frame(f, NBINS, NBINS - 1, 16'h8000);
    end
    gap_pct = 0;
    chk("c2_full", int'(full), 1);
    chk("c2_frame_count", int'(frame_count), 97);
    chk("c2_err_len", int'(err_len), 1);
    check_read(3 * 257, 35768, "c2_rd_3_0");
    check_read(4 * 257, 36768, "c2_rd_4_0");
    check_read(3 * 257 + 210, 3210, "c2_rd_stale");
    check_read(2 * 257 + 256, 35024, "c2_rd_2_256");

    // Capture 3: reset at frame 40
    release_i = 1'b1;
    tick();
    start = 1'b1;
    tick();
    for (int f = 0; f < 40; f++) send_frame(f, NBINS, NBINS - 1, 16'h4000);
    @(posedge clk);
    #1;
    arstn = 1'b0;
    model_reset();
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_frame_count", int'(frame_count), 0);
    repeat (2) tick();
    arstn = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) send_beat(16'(i), i == 19);
    chk("post_rst_busy", int'(busy), 0);
    chk("post_rst_frame_count", int'(frame_count), 0);
    tick();

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
